sm_ibuffer_sched: RTL and testbench
===================================

SM_IBUFFER_SCHED -- requirements
Module: sm_ibuffer_sched

Interface
REQ-001 Parameter NUM_WARP, default 8: number of warps, each with a private instruction FIFO.
REQ-002 Parameter IB_DEPTH, default 4: entries per warp FIFO, power of two, at least 2.
REQ-003 Parameter IB_DATA_WIDTH, default 136: width of one decoded-instruction word (inst + decode fields + wid).
REQ-004 Localparam WID_W = $clog2(NUM_WARP); localparam CNT_W = $clog2(IB_DEPTH)+1.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 wr_valid_i  input  1  decoded instruction present this cycle.
REQ-009 wr_wid_i  input  WID_W  target warp of the write.
REQ-010 wr_data_i  input  IB_DATA_WIDTH  decoded instruction word.
REQ-011 stall_i  input  NUM_WARP  per-warp issue block from the scoreboard.
REQ-012 issue_ready_i  input  1  downstream accepts the issued instruction.
REQ-013 issue_valid_o  output  1  an instruction is offered.
REQ-014 issue_wid_o  output  WID_W  warp of the offered instruction.
REQ-015 issue_data_o  output  IB_DATA_WIDTH  head entry of the selected warp.
REQ-016 has_data_o  output  NUM_WARP  bit w set when count[w] != 0.
REQ-017 avail_o  output  NUM_WARP  bit w set when count[w] < IB_DEPTH; consumed by fetch.
REQ-018 overflow_o  output  1  one-cycle pulse when a write targets a full warp.
REQ-019 flush_valid_i  input  1  discard all entries of one warp; present only under SM_IBUF_FLUSH_EN.
REQ-020 flush_wid_i  input  WID_W  warp to flush; present only under SM_IBUF_FLUSH_EN.

Function
REQ-021 Storage: per warp, a circular FIFO with rd_ptr, wr_ptr (log2 IB_DEPTH bits, natural wrap) and count (CNT_W bits).
REQ-022 Write: wr_valid_i with count[wid] < IB_DEPTH stores wr_data_i at wr_ptr[wid] and increments wr_ptr and count at the clock edge.
REQ-023 Write to a full warp: dropped with no state change; overflow_o = 1 the next cycle only.
REQ-024 Write latency: a written entry is first visible on issue_data_o the cycle after the write; no bypass.
REQ-025 Eligibility: warp w is eligible when count[w] != 0, stall_i[w] = 0 and w is not being flushed this cycle.
REQ-026 Selection: round-robin, combinational; search starts at rr_ptr+1 mod NUM_WARP, and the first eligible warp wins.
REQ-027 issue_valid_o = any eligible warp; issue_wid_o and issue_data_o reflect the selected warp's head.
REQ-028 Handshake: when issue_valid_o && issue_ready_i, pop the selected warp (rd_ptr+1, count-1) and set rr_ptr = issue_wid_o.
REQ-029 Without a handshake, rr_ptr holds, so the selection is stable unless stall_i or a flush changes eligibility.
REQ-030 Push and pop on the same warp in the same cycle: both happen, count unchanged; also legal when full (pop frees a slot, write accepted, no overflow).
REQ-031 Writes and pops on different warps are independent in the same cycle.
REQ-032 All NUM_WARP bits of stall_i set: issue_valid_o = 0; no state changes except writes.

Reset
REQ-033 While rst = 1 at a clock edge: all counts, rd_ptr and wr_ptr = 0; rr_ptr = NUM_WARP-1, so warp 0 has first priority.
REQ-034 Outputs the cycle after reset: issue_valid_o = 0, has_data_o = 0, avail_o = all ones, overflow_o = 0.
REQ-035 rst has priority over simultaneous write, pop and flush; in-flight entries are lost.
REQ-036 Storage array contents are not reset.

Configuration
REQ-037 Macro SM_IBUF_FLUSH_EN defined: flush ports exist; flush_valid_i zeroes count, rd_ptr and wr_ptr of flush_wid_i at the edge.
REQ-038 Flush priority: flush wins over a same-cycle write to that warp (write dropped, no overflow); the flushed warp is ineligible that cycle.
REQ-039 Macro SM_IBUF_FLUSH_EN undefined: flush ports and flush logic are absent; all other behaviour is identical.

Verification
REQ-040 After reset, write warp 3 with data 0xA5, issue_ready_i = 1 -> next cycle issue_valid_o = 1, issue_wid_o = 3, data 0xA5; the cycle after, has_data_o[3] = 0.
REQ-041 Warps 0, 1 and 2 each hold 2 entries, ready held high -> issue order 0,1,2,0,1,2; hold ready low 3 cycles mid-stream -> wid and data stable.
REQ-042 Fill warp 5 with IB_DEPTH = 4 writes -> avail_o[5] = 0; 5th write -> overflow_o pulses once, count stays 4; write plus pop on full warp 5 -> count 4, no overflow.
REQ-043 stall_i = 0x02 with warps 1 and 4 non-empty -> only warp 4 issues; release stall -> warp 1 issues next.
REQ-044 Under SM_IBUF_FLUSH_EN, warp 2 holds 3 entries; flush warp 2 with a same-cycle write to warp 2 -> count 0, write discarded, issue_valid_o does not select warp 2.
REQ-045 Assert rst mid-stream with 6 warps occupied -> next cycle all counters 0, avail_o all ones, first issue after refill comes from the lowest eligible warp.

Source files
------------

// File: rtl/sm_ibuffer_sched.sv
// Per-warp decoded-instruction FIFOs with a round-robin issue selector.
// Optional per-warp flush port enabled by defining SM_IBUF_FLUSH_EN.
module sm_ibuffer_sched #(
  parameter int unsigned NUM_WARP      = 8,
  parameter int unsigned IB_DEPTH      = 4,
  parameter int unsigned IB_DATA_WIDTH = 136,
  localparam int unsigned WID_W        = $clog2(NUM_WARP),
  localparam int unsigned CNT_W        = $clog2(IB_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  input  logic [WID_W-1:0]         wr_wid_i,
  input  logic [IB_DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_WARP-1:0]      stall_i,
  input  logic                     issue_ready_i,
`ifdef SM_IBUF_FLUSH_EN
  input  logic                     flush_valid_i,
  input  logic [WID_W-1:0]         flush_wid_i,
`endif
  output logic                     issue_valid_o,
  output logic [WID_W-1:0]         issue_wid_o,
  output logic [IB_DATA_WIDTH-1:0] issue_data_o,
  output logic [NUM_WARP-1:0]      has_data_o,
  output logic [NUM_WARP-1:0]      avail_o,
  output logic                     overflow_o
);

  localparam int unsigned PTR_W = $clog2(IB_DEPTH);

  logic [IB_DATA_WIDTH-1:0] mem_q [NUM_WARP][IB_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q [NUM_WARP];
  logic [PTR_W-1:0]         rd_ptr_d [NUM_WARP];
  logic [PTR_W-1:0]         wr_ptr_q [NUM_WARP];
  logic [PTR_W-1:0]         wr_ptr_d [NUM_WARP];
  logic [CNT_W-1:0]         count_q  [NUM_WARP];
  logic [CNT_W-1:0]         count_d  [NUM_WARP];
  logic [WID_W-1:0]         rr_q, rr_d;
  logic                     overflow_q, overflow_d;

  logic [NUM_WARP-1:0] flush_vec, full, eligible, wr_hit, push, pop;
  logic                sel_found, fire;
  logic [WID_W-1:0]    sel_wid;
  int unsigned         idx;

`ifdef SM_IBUF_FLUSH_EN
  assign flush_vec = flush_valid_i ? (NUM_WARP'(1) << flush_wid_i) : '0;
`else
  assign flush_vec = '0;
`endif

  always_comb begin
    for (int unsigned w = 0; w < NUM_WARP; w++) begin
      full[w]       = (count_q[w] == CNT_W'(IB_DEPTH));
      has_data_o[w] = (count_q[w] != '0);
      avail_o[w]    = !full[w];
      eligible[w]   = has_data_o[w] && !stall_i[w] && !flush_vec[w];
    end
  end

  // Search starts one past the last issued warp so every warp gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_wid   = rr_q;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_WARP; i++) begin
      idx = (32'(rr_q) + i) % NUM_WARP;
      if (!sel_found && eligible[idx]) begin
        sel_found = 1'b1;
        sel_wid   = idx[WID_W-1:0];
      end
    end
  end

  assign issue_valid_o = sel_found;
  assign issue_wid_o   = sel_wid;
  assign issue_data_o  = mem_q[sel_wid][rd_ptr_q[sel_wid]];
  assign fire          = sel_found && issue_ready_i;
  assign overflow_o    = overflow_q;

  always_comb begin
    overflow_d = 1'b0;
    rr_d       = fire ? sel_wid : rr_q;
    for (int unsigned w = 0; w < NUM_WARP; w++) begin
      pop[w]    = fire && (sel_wid == WID_W'(w));
      wr_hit[w] = wr_valid_i && (wr_wid_i == WID_W'(w)) && !flush_vec[w];
      // A same-cycle pop frees a slot, so a write to a full warp is still accepted.
      push[w]   = wr_hit[w] && (!full[w] || pop[w]);
      if (wr_hit[w] && full[w] && !pop[w]) overflow_d = 1'b1;
      if (flush_vec[w]) begin
        rd_ptr_d[w] = '0;
        wr_ptr_d[w] = '0;
        count_d[w]  = '0;
      end else begin
        rd_ptr_d[w] = rd_ptr_q[w] + PTR_W'(pop[w]);
        wr_ptr_d[w] = wr_ptr_q[w] + PTR_W'(push[w]);
        count_d[w]  = count_q[w] + CNT_W'(push[w]) - CNT_W'(pop[w]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < NUM_WARP; w++) begin
        rd_ptr_q[w] <= '0;
        wr_ptr_q[w] <= '0;
        count_q[w]  <= '0;
      end
      rr_q       <= WID_W'(NUM_WARP - 1);
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARP; w++) begin
        rd_ptr_q[w] <= rd_ptr_d[w];
        wr_ptr_q[w] <= wr_ptr_d[w];
        count_q[w]  <= count_d[w];
      end
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; counts alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NUM_WARP; w++) begin
      if (push[w]) mem_q[w][wr_ptr_q[w]] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_sm_ibuffer_sched.sv
// Directed table-driven bench for sm_ibuffer_sched (default parameters).
// Flush sequence is compiled in only when SM_IBUF_FLUSH_EN is defined.
module tb_sm_ibuffer_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid_i;
  logic [2:0]   wr_wid_i;
  logic [135:0] wr_data_i;
  logic [7:0]   stall_i;
  logic         issue_ready_i;
  logic         flush_valid_i;
  logic [2:0]   flush_wid_i;
  logic         issue_valid_o;
  logic [2:0]   issue_wid_o;
  logic [135:0] issue_data_o;
  logic [7:0]   has_data_o;
  logic [7:0]   avail_o;
  logic         overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_ibuffer_sched dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid_i    (wr_valid_i),
    .wr_wid_i      (wr_wid_i),
    .wr_data_i     (wr_data_i),
    .stall_i       (stall_i),
    .issue_ready_i (issue_ready_i),
`ifdef SM_IBUF_FLUSH_EN
    .flush_valid_i (flush_valid_i),
    .flush_wid_i   (flush_wid_i),
`endif
    .issue_valid_o (issue_valid_o),
    .issue_wid_o   (issue_wid_o),
    .issue_data_o  (issue_data_o),
    .has_data_o    (has_data_o),
    .avail_o       (avail_o),
    .overflow_o    (overflow_o)
  );

  typedef struct {
    logic         rs;
    logic         fv;
    logic [2:0]   fw;
    logic         wv;
    logic [2:0]   ww;
    logic [135:0] wd;
    logic [7:0]   st;
    logic         rdy;
    logic         ev;
    logic [2:0]   ewid;
    logic [135:0] ed;
    logic [7:0]   eh;
    logic [7:0]   ea;
    logic         eo;
  } vec_t;

  vec_t vecs[$];
  int   row = 0;

  function automatic vec_t mk(input int wv, input int ww, input int wd, input int st,
                              input int rdy, input int ev, input int ewid, input int ed,
                              input int eh, input int ea, input int eo);
    vec_t v;
    v.rs = 1'b0; v.fv = 1'b0; v.fw = 3'd0;
    v.wv = wv[0]; v.ww = ww[2:0]; v.wd = 136'(wd); v.st = st[7:0]; v.rdy = rdy[0];
    v.ev = ev[0]; v.ewid = ewid[2:0]; v.ed = 136'(ed);
    v.eh = eh[7:0]; v.ea = ea[7:0]; v.eo = eo[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int n, input logic [135:0] act,
                     input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the edge.
  task automatic apply(input vec_t v);
    rst           = v.rs;
    flush_valid_i = v.fv;
    flush_wid_i   = v.fw;
    wr_valid_i    = v.wv;
    wr_wid_i      = v.ww;
    wr_data_i     = v.wd;
    stall_i       = v.st;
    issue_ready_i = v.rdy;
    #4;
    chk("issue_valid", row, 136'(issue_valid_o), 136'(v.ev));
    if (v.ev) begin
      chk("issue_wid", row, 136'(issue_wid_o), 136'(v.ewid));
      chk("issue_data", row, issue_data_o, v.ed);
    end
    chk("has_data", row, 136'(has_data_o), 136'(v.eh));
    chk("avail", row, 136'(avail_o), 136'(v.ea));
    chk("overflow", row, 136'(overflow_o), 136'(v.eo));
    row++;
    @(posedge clk);
    #1;
  endtask

  vec_t v;

  initial begin
    rst = 1'b1; flush_valid_i = 1'b0; flush_wid_i = '0; wr_valid_i = 1'b0;
    wr_wid_i = '0; wr_data_i = '0; stall_i = '0; issue_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            wv ww wd    st    rdy ev wid ed    has   avail ovf
    vecs.push_back(mk(0, 0, 0,    0,    1, 0, 0, 0,    8'h00, 8'hFF, 0)); // reset state
    vecs.push_back(mk(1, 3, 'hA5, 0,    1, 0, 0, 0,    8'h00, 8'hFF, 0)); // no bypass
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 3, 'hA5, 8'h08, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 0, 0, 0,    8'h00, 8'hFF, 0));
    vecs.push_back(mk(1, 0, 'h10, 0,    0, 0, 0, 0,    8'h00, 8'hFF, 0)); // fill 0,1,2
    vecs.push_back(mk(1, 0, 'h11, 0,    0, 1, 0, 'h10, 8'h01, 8'hFF, 0));
    vecs.push_back(mk(1, 1, 'h20, 0,    0, 1, 0, 'h10, 8'h01, 8'hFF, 0));
    vecs.push_back(mk(1, 1, 'h21, 0,    0, 1, 0, 'h10, 8'h03, 8'hFF, 0));
    vecs.push_back(mk(1, 2, 'h30, 0,    0, 1, 0, 'h10, 8'h03, 8'hFF, 0));
    vecs.push_back(mk(1, 2, 'h31, 0,    0, 1, 0, 'h10, 8'h07, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 0, 'h10, 8'h07, 8'hFF, 0)); // round robin
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 1, 'h20, 8'h07, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    0, 1, 2, 'h30, 8'h07, 8'hFF, 0)); // ready low x3
    vecs.push_back(mk(0, 0, 0,    0,    0, 1, 2, 'h30, 8'h07, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    0, 1, 2, 'h30, 8'h07, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 2, 'h30, 8'h07, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 0, 'h11, 8'h07, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 1, 'h21, 8'h06, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 2, 'h31, 8'h04, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 0, 0, 0,    8'h00, 8'hFF, 0));
    vecs.push_back(mk(1, 5, 'h50, 0,    0, 0, 0, 0,    8'h00, 8'hFF, 0)); // fill warp 5
    vecs.push_back(mk(1, 5, 'h51, 0,    0, 1, 5, 'h50, 8'h20, 8'hFF, 0));
    vecs.push_back(mk(1, 5, 'h52, 0,    0, 1, 5, 'h50, 8'h20, 8'hFF, 0));
    vecs.push_back(mk(1, 5, 'h53, 0,    0, 1, 5, 'h50, 8'h20, 8'hFF, 0));
    vecs.push_back(mk(1, 5, 'h54, 0,    0, 1, 5, 'h50, 8'h20, 8'hDF, 0)); // overflowing write
    vecs.push_back(mk(1, 5, 'h55, 0,    1, 1, 5, 'h50, 8'h20, 8'hDF, 1)); // push+pop on full
    vecs.push_back(mk(0, 0, 0,    0,    0, 1, 5, 'h51, 8'h20, 8'hDF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 5, 'h51, 8'h20, 8'hDF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 5, 'h52, 8'h20, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 5, 'h53, 8'h20, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 5, 'h55, 8'h20, 8'hFF, 0)); // wrapped slot
    vecs.push_back(mk(1, 1, 'h61, 8'h02, 0, 0, 0, 0,   8'h00, 8'hFF, 0)); // stall warp 1
    vecs.push_back(mk(1, 4, 'h64, 8'h02, 0, 0, 0, 0,   8'h02, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    8'h02, 1, 1, 4, 'h64, 8'h12, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    8'h02, 0, 0, 0, 0,   8'h02, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 1, 'h61, 8'h02, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 0, 0, 0,    8'h00, 8'hFF, 0));
    vecs.push_back(mk(1, 6, 'h66, 8'hFF, 1, 0, 0, 0,   8'h00, 8'hFF, 0)); // all stalled
    vecs.push_back(mk(0, 0, 0,    8'hFF, 1, 0, 0, 0,   8'h40, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 1, 6, 'h66, 8'h40, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 0,    0,    1, 0, 0, 0,    8'h00, 8'hFF, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset mid-stream with warps 0..5 occupied, then refill 5, 2, 0.
    apply(mk(1, 0, 'h80, 0, 0, 0, 0, 0,    8'h00, 8'hFF, 0));
    apply(mk(1, 1, 'h81, 0, 0, 1, 0, 'h80, 8'h01, 8'hFF, 0));
    apply(mk(1, 2, 'h82, 0, 0, 1, 0, 'h80, 8'h03, 8'hFF, 0));
    apply(mk(1, 3, 'h83, 0, 0, 1, 0, 'h80, 8'h07, 8'hFF, 0));
    apply(mk(1, 4, 'h84, 0, 0, 1, 0, 'h80, 8'h0F, 8'hFF, 0));
    apply(mk(1, 5, 'h85, 0, 0, 1, 0, 'h80, 8'h1F, 8'hFF, 0));
    v = mk(1, 6, 'h86, 0, 1, 1, 0, 'h80, 8'h3F, 8'hFF, 0);
    v.rs = 1'b1;
    apply(v);
    apply(mk(0, 0, 0,    0, 0, 0, 0, 0,    8'h00, 8'hFF, 0));
    apply(mk(1, 5, 'h95, 0, 0, 0, 0, 0,    8'h00, 8'hFF, 0));
    apply(mk(1, 2, 'h92, 0, 0, 1, 5, 'h95, 8'h20, 8'hFF, 0));
    apply(mk(1, 0, 'h90, 0, 0, 1, 2, 'h92, 8'h24, 8'hFF, 0));
    apply(mk(0, 0, 0,    0, 1, 1, 0, 'h90, 8'h25, 8'hFF, 0));
    apply(mk(0, 0, 0,    0, 1, 1, 2, 'h92, 8'h24, 8'hFF, 0));
    apply(mk(0, 0, 0,    0, 1, 1, 5, 'h95, 8'h20, 8'hFF, 0));
    apply(mk(0, 0, 0,    0, 1, 0, 0, 0,    8'h00, 8'hFF, 0));

`ifdef SM_IBUF_FLUSH_EN
    apply(mk(1, 2, 'hB0, 0, 0, 0, 0, 0,    8'h00, 8'hFF, 0));
    apply(mk(1, 2, 'hB1, 0, 0, 1, 2, 'hB0, 8'h04, 8'hFF, 0));
    apply(mk(1, 2, 'hB2, 0, 0, 1, 2, 'hB0, 8'h04, 8'hFF, 0));
    v = mk(1, 2, 'hB3, 0, 1, 0, 0, 0, 8'h04, 8'hFF, 0);
    v.fv = 1'b1;
    v.fw = 3'd2;
    apply(v);
    apply(mk(0, 0, 0,    0, 1, 0, 0, 0,    8'h00, 8'hFF, 0));
    apply(mk(1, 2, 'hC0, 0, 0, 0, 0, 0,    8'h00, 8'hFF, 0));
    apply(mk(0, 0, 0,    0, 1, 1, 2, 'hC0, 8'h04, 8'hFF, 0));
    apply(mk(0, 0, 0,    0, 1, 0, 0, 0,    8'h00, 8'hFF, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
